serial_cla_subtractor: RTL and testbench



---
 rtl/serial_cla_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_cla_subtractor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_cla_subtractor.sv
// serial_cla_subtractor: multi-cycle DIGIT-per-clock lookahead subtractor (optional add mode via ADDSUB_MODE_EN)
module serial_cla_subtractor #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
`ifdef ADDSUB_MODE_EN
   input  logic             op,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             overflow,
   output logic             zero
);
   localparam int N = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int MSB = WIDTH - 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_diff;
   logic [CW-1:0]    r_cnt;
   logic             r_brw, r_bout, r_ovf, r_zero;
   logic             w_op, w_accept, w_last, w_cin, w_gg, w_pp, w_brw_next, w_ovf_full;
   logic [DIGIT-1:0] w_x, w_y, w_g, w_p, w_sum;
   logic [DIGIT:0]   w_c;
   logic [WIDTH-1:0] w_diff_full;

`ifdef ADDSUB_MODE_EN
   logic r_op;
   // operation select is captured alongside the operands
   always_ff @(posedge clk) begin
      if (rst) r_op <= 1'b0;
      else if (w_accept) r_op <= op;
   end
   assign w_op = r_op;
`else
   assign w_op = 1'b0;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   end

   // next-state and handshake outputs
   always_comb begin
      w_accept = (r_state == IDLE) && in_valid;
      w_last = r_cnt == LAST;
      w_next = r_state;
      if (w_accept) w_next = RUN;
      else if (r_state == RUN && w_last) w_next = DONE;
      else if (r_state == DONE && out_ready) w_next = IDLE;
      in_ready = r_state == IDLE;
      out_valid = r_state == DONE;
   end

   // one lookahead slice: subtraction is a + ~b + ~borrow, addition is a + b + carry
   always_comb begin
      w_x = r_a[r_cnt*DIGIT +: DIGIT];
      w_y = w_op ? r_b[r_cnt*DIGIT +: DIGIT] : ~r_b[r_cnt*DIGIT +: DIGIT];
      w_cin = w_op ? r_brw : ~r_brw;
      w_g = w_x & w_y;
      w_p = w_x ^ w_y;
      w_c = '0;
      w_c[0] = w_cin;
      w_gg = 1'b0;
      w_pp = 1'b1;
      for (int i = 0; i < DIGIT; i++) begin
         w_gg = 1'b0;
         w_pp = 1'b1;
         for (int j = i; j >= 0; j--) begin
            w_gg = w_gg | (w_g[j] & w_pp);
            w_pp = w_pp & w_p[j];
         end
         w_c[i+1] = w_gg | (w_pp & w_cin);
      end
      w_sum = w_p ^ w_c[DIGIT-1:0];
      w_brw_next = w_op ? w_c[DIGIT] : ~w_c[DIGIT];
      w_diff_full = r_diff;
      w_diff_full[r_cnt*DIGIT +: DIGIT] = w_sum;
      w_ovf_full = w_op ? (r_a[MSB] == r_b[MSB]) && (w_diff_full[MSB] != r_a[MSB])
                        : (r_a[MSB] != r_b[MSB]) && (w_diff_full[MSB] != r_a[MSB]);
   end

   // operand capture, slice accumulation, and flag registration on the final slice
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a <= '0;
         r_b <= '0;
         r_diff <= '0;
         r_cnt <= '0;
         r_brw <= 1'b0;
         r_bout <= 1'b0;
         r_ovf <= 1'b0;
         r_zero <= 1'b0;
      end else if (w_accept) begin
         r_a <= a;
         r_b <= b;
         r_brw <= b_in;
         r_cnt <= '0;
      end else if (r_state == RUN) begin
         r_diff <= w_diff_full;
         r_brw <= w_brw_next;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_bout <= w_brw_next;
            r_ovf <= w_ovf_full;
            r_zero <= ~|w_diff_full;
         end
      end
   end

   assign diff = r_diff;
   assign b_out = r_bout;
   assign overflow = r_ovf;
   assign zero = r_zero;
endmodule

// File: tb/tb_serial_cla_subtractor.sv
// tb_serial_cla_subtractor: scoreboard bench with random and directed operands against an arithmetic model
module tb_serial_cla_subtractor;
   localparam int W = 16;
   localparam int D = 4;
   localparam int N = W / D;

   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, b_in = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, b_out, overflow, zero;
   logic [W-1:0] a = '0, b = '0, diff;

   typedef struct {
      logic [W-1:0] d;
      logic bo;
      logic ov;
      logic z;
      int acc;
   } exp_t;

   exp_t sb[$];
   int checks = 0, failures = 0, cyc = 0, last_acc = -1000;
   logic prev_ov = 1'b0;

   always #5 clk = ~clk;

   serial_cla_subtractor #(.WIDTH(W), .DIGIT(D)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .b_out(b_out), .overflow(overflow), .zero(zero)
   );

   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin, input int acc);
      exp_t e;
      int s;
      s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
      e.d = W'(int'(ma) - int'(mb) - int'(mbin));
      e.bo = int'(ma) < int'(mb) + int'(mbin);
      e.ov = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
      e.z = e.d == '0;
      e.acc = acc;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, req, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // issue side: every accepted operand set pushes its expected result
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         sb.delete();
         last_acc <= -1000;
      end else if (in_valid && in_ready) begin
         chk("accept_interval_ok", 32'(cyc + 1 - last_acc >= N + 2), 32'd1);
         sb.push_back(model(a, b, b_in, cyc + 1));
         last_acc <= cyc + 1;
      end
   end

   // monitor: compare presented results with the head of the scoreboard
   always @(negedge clk) begin
      if (out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual diff=%0h expected no result", diff);
         end else begin
            if (!prev_ov) chk("latency", 32'(cyc - sb[0].acc), 32'(N));
            chk("diff", 32'(diff), 32'(sb[0].d));
            chk("b_out", 32'(b_out), 32'(sb[0].bo));
            chk("overflow", 32'(overflow), 32'(sb[0].ov));
            chk("zero", 32'(zero), 32'(sb[0].z));
            chk("in_ready_in_done", 32'(in_ready), 32'd0);
            if (out_ready) void'(sb.pop_front());
         end
      end
      prev_ov <= out_valid;
   end

   task automatic run_op(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin, input int hold);
      int t;
      t = 0;
      while (!in_ready && t < 50) begin
         step();
         t++;
      end
      a = ma;
      b = mb;
      b_in = mbin;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      b_in = 1'($urandom);
      t = 0;
      while (!out_valid && t < 50) begin
         step();
         t++;
      end
      if (!out_valid) begin
         checks++;
         failures++;
         $display("FAIL out_valid_timeout actual=0 expected=1");
      end
      repeat (hold) begin
         in_valid = 1'b1;
         a = W'($urandom);
         b = W'($urandom);
         b_in = 1'($urandom);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("out_valid_drop", 32'(out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ra;
      rst = 1'b1;
      step();
      step();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_flags", {29'd0, b_out, overflow, zero}, 32'd0);
      rst = 1'b0;
      run_op(16'h1234, 16'h0234, 1'b0, 0);
      run_op(16'h0100, 16'h0001, 1'b0, 0);
      run_op(16'h0000, 16'h0001, 1'b0, 0);
      run_op(16'h8000, 16'h0001, 1'b0, 0);
      run_op(16'h7FFF, 16'hFFFF, 1'b0, 0);
      run_op(16'h5555, 16'h5554, 1'b1, 0);
      run_op(16'hABCD, 16'h1357, 1'b0, 3);
      run_op(16'h0F0F, 16'hF0F0, 1'b1, 0);
      while (!in_ready) step();
      a = 16'hC3A5;
      b = 16'h1234;
      b_in = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      in_valid = 1'b1;
      a = 16'h0001;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
      chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
      chk("midrun_rst_diff", 32'(diff), 32'd0);
      run_op(16'h4000, 16'h4001, 1'b0, 0);
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         run_op(ra, (i % 8 == 0) ? ra : W'($urandom), 1'($urandom), $urandom_range(0, 2));
      end
      step();
      step();
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
